ps2_pitch_encoder: RTL and testbench

Front end of the keyboard-piano datapath. Receives PS/2 keyboard frames, tracks make/break (F0) sequences, and encodes the eight piano keys into the 8-bit pitch code consumed by the tone generator and the two-digit seven-segment pitch display. Holds the code of the currently held key and returns to 8'h00 when that key is released.

---
 rtl/ps2_pitch_encoder_if.sv | 26 ++
 rtl/ps2_pitch_encoder.sv | 147 ++++++++++++++
 tb/tb_ps2_pitch_encoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pitch_encoder_if.sv
// PS/2 line and pitch-code bundle for ps2_pitch_encoder.
// master: keyboard/stimulus side driving the PS/2 lines and observing the code.
// slave:  encoder side consuming the PS/2 lines and producing the code.
interface ps2_pitch_encoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] pitch;
  logic       pitch_valid;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  pitch,
    input  pitch_valid,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output pitch,
    output pitch_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_pitch_encoder.sv
// ps2_pitch_encoder: PS/2 frame receiver plus make/break decoder that maps
// eight piano keys to an 8-bit pitch code (8'h00 = no key held).
// Optional build macro PS2_PARITY_CHECK_EN: reject frames whose odd parity
// fails (frame_err pulse); otherwise the parity bit is ignored.
module ps2_pitch_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                 clk,
  input logic                 clrn,
  ps2_pitch_encoder_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, BREAK} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fall;
  logic          data_bit;

  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          frame_err_q;

  logic [7:0]    key;
  logic          odd_parity;
  logic          parity_ok;
  logic          frame_bad;
  logic          byte_ok;

  state_t        state_q, state_d;
  logic [7:0]    pitch_q, pitch_d;
  logic          pitch_valid_q;
  logic [7:0]    code;

  function automatic logic [7:0] map_key(input logic [7:0] b);
    logic [7:0] r;
    case (b)
      8'h1C:   r = 8'hC5;
      8'h1B:   r = 8'hD5;
      8'h23:   r = 8'hE5;
      8'h2B:   r = 8'hF5;
      8'h34:   r = 8'h05;
      8'h33:   r = 8'hA5;
      8'h3B:   r = 8'hB5;
      8'h42:   r = 8'hC6;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Two-flop synchronisers plus a history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[1];
  assign data_bit = data_sync[1];

  // Start and stop bits are judged as they arrive, so only data and parity
  // are retained; after bit 9 shreg[7:0] is the byte and shreg[8] the parity.
  assign key        = shreg[7:0];
  assign odd_parity = ^shreg;

  // Frame validity for the current detect cycle
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    parity_ok = odd_parity;
`else
    parity_ok = odd_parity | 1'b1;
`endif
    frame_bad = fall && (((bit_cnt == 4'd0) && data_bit) ||
                         ((bit_cnt == 4'd10) && (!data_bit || !parity_ok)));
    byte_ok   = fall && (bit_cnt == 4'd10) && data_bit && parity_ok;
  end

  // Bit counter, shift register, idle timeout and frame_err pulse
  always_ff @(posedge clk) begin
    if (!clrn) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      if (fall) begin
        tcnt <= '0;
        if (bit_cnt != 4'd0 && bit_cnt != 4'd10) shreg <= {data_bit, shreg[8:1]};
        if (frame_bad || bit_cnt == 4'd10) bit_cnt <= '0;
        else                               bit_cnt <= bit_cnt + 4'd1;
      end else begin
        if (tcnt != TMAX) tcnt <= tcnt + TW'(1);
        if (bit_cnt != 4'd0 && tcnt == TMAX) bit_cnt <= '0;
      end
    end
  end

  // Decoder next-state and next-pitch on each accepted byte
  always_comb begin
    state_d = state_q;
    pitch_d = pitch_q;
    code    = map_key(key);
    if (byte_ok) begin
      case (state_q)
        IDLE: begin
          if (key == 8'hF0)      state_d = BREAK;
          else if (code != '0)   pitch_d = code;
        end
        BREAK: begin
          state_d = IDLE;
          if (code != '0 && code == pitch_q) pitch_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoder state, pitch register and change pulse
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q       <= IDLE;
      pitch_q       <= '0;
      pitch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pitch_q       <= pitch_d;
      pitch_valid_q <= (pitch_d != pitch_q);
    end
  end

  assign bus.pitch       = pitch_q;
  assign bus.pitch_valid = pitch_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_pitch_encoder.sv
// Self-checking bench for ps2_pitch_encoder: directed scenarios followed by
// randomized key traffic, all compared against a key-table reference model.
module tb_ps2_pitch_encoder;

  localparam int unsigned TO   = 200;
  localparam int unsigned HALF = 15;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  ps2_pitch_encoder_if bus();

  ps2_pitch_encoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned pv_cnt   = 0;
  int unsigned fe_cnt   = 0;
  int unsigned exp_pv   = 0;
  int unsigned exp_fe   = 0;

  logic [7:0] m_pitch;
  bit         m_break;
  logic [7:0] keymap [logic [7:0]];
  logic [7:0] keys [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      if (bus.pitch_valid === 1'b1) pv_cnt++;
      if (bus.frame_err === 1'b1)   fe_cnt++;
    end
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      wait_cycles(HALF);
      bus.ps2_clk = 1'b0;
      wait_cycles(HALF);
      bus.ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_word(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic [10:0] w;
    w[0]    = 1'b0;
    w[8:1]  = b;
    w[9]    = ~(^b) ^ bad_par;
    w[10]   = ~bad_stop;
    return w;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] nxt;
    nxt = m_pitch;
    if (m_break) begin
      m_break = 1'b0;
      if (keymap.exists(b) && keymap[b] == m_pitch) nxt = 8'h00;
    end else if (b == 8'hF0) begin
      m_break = 1'b1;
    end else if (keymap.exists(b)) begin
      nxt = keymap[b];
    end
    if (nxt != m_pitch) exp_pv++;
    m_pitch = nxt;
  endtask

  task automatic check_state(input string tag);
    check({tag, ":pitch"},    {24'd0, bus.pitch}, {24'd0, m_pitch});
    check({tag, ":pv_count"}, pv_cnt, exp_pv);
    check({tag, ":fe_count"}, fe_cnt, exp_fe);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input bit bad_stop, input bit bad_par);
    send_raw(make_word(b, bad_stop, bad_par), 11);
    if (bad_stop) exp_fe++;
`ifdef PS2_PARITY_CHECK_EN
    else if (bad_par) exp_fe++;
`endif
    else model_byte(b);
    wait_cycles(6);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] b;
    int unsigned r;
    bit bs, bp;

    keymap[8'h1C] = 8'hC5; keymap[8'h1B] = 8'hD5;
    keymap[8'h23] = 8'hE5; keymap[8'h2B] = 8'hF5;
    keymap[8'h34] = 8'h05; keymap[8'h33] = 8'hA5;
    keymap[8'h3B] = 8'hB5; keymap[8'h42] = 8'hC6;
    keys = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    m_pitch = 8'h00;
    m_break = 1'b0;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    clrn = 1'b0;
    wait_cycles(3);
    check("reset:pitch",       {24'd0, bus.pitch}, 32'h0);
    check("reset:pitch_valid", {31'd0, bus.pitch_valid}, 32'h0);
    check("reset:frame_err",   {31'd0, bus.frame_err}, 32'h0);
    clrn = 1'b1;
    wait_cycles(5);

    send_frame("make_1C", 8'h1C, 0, 0);
    send_frame("brk_F0", 8'hF0, 0, 0);
    send_frame("brk_1C", 8'h1C, 0, 0);

    send_frame("make_34", 8'h34, 0, 0);
    send_frame("typematic_34a", 8'h34, 0, 0);
    send_frame("typematic_34b", 8'h34, 0, 0);
    send_frame("brk_F0", 8'hF0, 0, 0);
    send_frame("brk_34", 8'h34, 0, 0);

    send_frame("make_1C", 8'h1C, 0, 0);
    send_frame("make_42", 8'h42, 0, 0);
    send_frame("brk_F0", 8'hF0, 0, 0);
    send_frame("brk_1C_stale", 8'h1C, 0, 0);
    send_frame("brk_F0", 8'hF0, 0, 0);
    send_frame("brk_42", 8'h42, 0, 0);

    send_frame("unmapped_15", 8'h15, 0, 0);
    send_frame("ext_E0", 8'hE0, 0, 0);
    send_frame("ext_75", 8'h75, 0, 0);

    // Single falling edge with data high: bad start bit
    send_raw(11'h7FF, 1);
    exp_fe++;
    wait_cycles(6);
    check_state("bad_start");

    send_frame("bad_stop_1C", 8'h1C, 1, 0);
    send_frame("bad_parity_1C", 8'h1C, 0, 1);
    send_frame("rel_F0", 8'hF0, 0, 0);
    send_frame("rel_1C", 8'h1C, 0, 0);

    // Abandoned partial frame, then a clean frame after the idle timeout
    send_raw(make_word(8'h1B, 0, 0), 5);
    wait_cycles(TO + 10);
    check_state("timeout_idle");
    send_frame("after_timeout_23", 8'h23, 0, 0);
    send_frame("brk_F0", 8'hF0, 0, 0);
    send_frame("brk_23", 8'h23, 0, 0);

    // Reset mid-frame with a pending BREAK and a held key
    send_frame("pre_rst_1C", 8'h1C, 0, 0);
    send_frame("pre_rst_F0", 8'hF0, 0, 0);
    send_raw(make_word(8'h3B, 0, 0), 4);
    clrn = 1'b0;
    wait_cycles(1);
    check("midrst:pitch",       {24'd0, bus.pitch}, 32'h0);
    check("midrst:pitch_valid", {31'd0, bus.pitch_valid}, 32'h0);
    check("midrst:frame_err",   {31'd0, bus.frame_err}, 32'h0);
    clrn = 1'b1;
    m_pitch = 8'h00;
    m_break = 1'b0;
    wait_cycles(3);
    send_frame("post_rst_3B", 8'h3B, 0, 0);

    for (int unsigned n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4 || r == 9) b = keys[$urandom_range(0, 7)];
      else if (r <= 6)      b = 8'hF0;
      else if (r == 7)      b = 8'hE0;
      else                  b = 8'($urandom_range(0, 255));
      bs = ($urandom_range(0, 15) == 0);
      bp = ($urandom_range(0, 9) == 0);
      send_frame("random", b, bs, bp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
